// File: rtl/mrr_es_burst_detect.sv
// Energy burst detector: tracks a noise floor from the Es stream, flags bursts
// above a scaled threshold and reports the peak value/offset within a bounded window.
module mrr_es_burst_detect #(
   parameter int unsigned ES_WIDTH         = 9,
   parameter int unsigned FLOOR_ALPHA_LOG2 = 6,
   parameter int unsigned MULT_WIDTH       = 8,
   parameter int unsigned WIN_WIDTH        = 12,
   parameter int unsigned HOLDOFF_WIDTH    = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     enable,
   input  logic                     settings_changed,
   input  logic [MULT_WIDTH-1:0]    setting_thresh_mult,
   input  logic [ES_WIDTH-1:0]      setting_min_thresh,
   input  logic [WIN_WIDTH-1:0]     setting_peak_win,
   input  logic [HOLDOFF_WIDTH-1:0] setting_holdoff,
   input  logic [ES_WIDTH-1:0]      es,
   output logic                     detect,
   output logic [ES_WIDTH-1:0]      peak_val,
   output logic [WIN_WIDTH-1:0]     peak_offset,
   output logic [ES_WIDTH-1:0]      noise_floor,
   output logic                     busy
);

   localparam int unsigned ACC_W  = ES_WIDTH + FLOOR_ALPHA_LOG2;
   localparam int unsigned PROD_W = ES_WIDTH + MULT_WIDTH;

   typedef enum logic [1:0] {WARMUP, IDLE, PEAK, HOLDOFF} state_t;

   state_t                    state, state_n;
   logic [ACC_W-1:0]          floor_acc, floor_acc_n;
   logic [FLOOR_ALPHA_LOG2-1:0] warm_cnt, warm_cnt_n;
   logic [WIN_WIDTH-1:0]      cnt, cnt_n;
   logic [WIN_WIDTH-1:0]      off_r, off_r_n;
   logic [ES_WIDTH-1:0]       peak_r, peak_r_n;
   logic [HOLDOFF_WIDTH-1:0]  hold_cnt, hold_cnt_n;
   logic                      detect_n;
   logic [ES_WIDTH-1:0]       peak_val_n;
   logic [WIN_WIDTH-1:0]      peak_offset_n;

   logic [PROD_W-1:0]         prod;
   logic [ES_WIDTH-1:0]       t_sat;
   logic [ES_WIDTH-1:0]       thresh;
   logic [WIN_WIDTH-1:0]      win_eff;

   logic                      done;
   logic [ES_WIDTH-1:0]       done_val;
   logic [WIN_WIDTH-1:0]      done_off;

   assign noise_floor = floor_acc[ACC_W-1:FLOOR_ALPHA_LOG2];
   assign busy        = (state != IDLE);

   assign prod    = PROD_W'(noise_floor) * PROD_W'(setting_thresh_mult);
   // Any bit above the ES range after the >>4 means the threshold saturates.
   assign t_sat   = (|prod[PROD_W-1:ES_WIDTH+4]) ? '1 : prod[ES_WIDTH+3:4];
   assign thresh  = (t_sat > setting_min_thresh) ? t_sat : setting_min_thresh;
   assign win_eff = (setting_peak_win == '0) ? WIN_WIDTH'(1) : setting_peak_win;

   always_comb begin
      state_n       = state;
      floor_acc_n   = floor_acc;
      warm_cnt_n    = warm_cnt;
      cnt_n         = cnt;
      off_r_n       = off_r;
      peak_r_n      = peak_r;
      hold_cnt_n    = hold_cnt;
      detect_n      = 1'b0;
      peak_val_n    = peak_val;
      peak_offset_n = peak_offset;
      done          = 1'b0;
      done_val      = '0;
      done_off      = '0;

      if (enable) begin
         case (state)
            WARMUP: begin
               floor_acc_n = floor_acc + ACC_W'(es);
               warm_cnt_n  = warm_cnt + 1'b1;
               if (warm_cnt == '1)
                  state_n = IDLE;
            end
            IDLE: begin
               if (es > thresh) begin
                  peak_r_n = es;
                  off_r_n  = '0;
                  cnt_n    = WIN_WIDTH'(1);
                  if (win_eff == WIN_WIDTH'(1)) begin
                     done     = 1'b1;
                     done_val = es;
                     done_off = '0;
                  end else begin
                     state_n = PEAK;
                  end
               end else begin
                  // Modular arithmetic is safe: the true result always fits ACC_W.
                  floor_acc_n = floor_acc + ACC_W'(es) - ACC_W'(noise_floor);
               end
            end
            PEAK: begin
               if (es <= thresh) begin
                  done     = 1'b1;
                  done_val = peak_r;
                  done_off = off_r;
               end else begin
                  if (es > peak_r) begin
                     peak_r_n = es;
                     off_r_n  = cnt;
                  end
                  cnt_n = cnt + 1'b1;
                  if (cnt_n >= win_eff) begin
                     done     = 1'b1;
                     done_val = peak_r_n;
                     done_off = off_r_n;
                  end
               end
            end
            HOLDOFF: begin
               hold_cnt_n = hold_cnt + 1'b1;
               if (hold_cnt_n >= setting_holdoff)
                  state_n = IDLE;
            end
            default: state_n = WARMUP;
         endcase

         if (done) begin
            detect_n      = 1'b1;
            peak_val_n    = done_val;
            peak_offset_n = done_off;
            hold_cnt_n    = '0;
            state_n       = (setting_holdoff != '0) ? HOLDOFF : IDLE;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst || settings_changed) begin
         state       <= WARMUP;
         floor_acc   <= '0;
         warm_cnt    <= '0;
         cnt         <= '0;
         off_r       <= '0;
         peak_r      <= '0;
         hold_cnt    <= '0;
         detect      <= 1'b0;
         peak_val    <= '0;
         peak_offset <= '0;
      end else begin
         state       <= state_n;
         floor_acc   <= floor_acc_n;
         warm_cnt    <= warm_cnt_n;
         cnt         <= cnt_n;
         off_r       <= off_r_n;
         peak_r      <= peak_r_n;
         hold_cnt    <= hold_cnt_n;
         detect      <= detect_n;
         peak_val    <= peak_val_n;
         peak_offset <= peak_offset_n;
      end
   end

endmodule
